// File: rtl/latency_ram_pkg.sv
// Shared definitions for latency_ram: FSM state encoding, counter width and
// the byte-offset helper that maps a byte address to a word index.
package latency_ram_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  localparam int unsigned CntWidth = 8;

  // Number of low address bits that select a byte within a word.
  function automatic int unsigned byte_off(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/latency_ram_array.sv
// Word storage for latency_ram: synchronous write with per-byte enable and
// asynchronous read on a single shared word index.
module latency_ram_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [DEPTH_LOG2-1:0]   idx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wmask,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned Depth    = 1 << DEPTH_LOG2;
  localparam int unsigned NumBytes = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (wmask[b]) begin
          mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/latency_ram.sv
// Variable-latency single-port memory with en/hasFinished handshake.
// Optional per-byte write mask enabled by defining LATENCY_RAM_BYTE_MASK_EN.
module latency_ram
  import latency_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   data_in,
`ifdef LATENCY_RAM_BYTE_MASK_EN
  input  logic [DATA_WIDTH/8-1:0] byte_mask,
`endif
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    busy,
  output logic                    hasFinished
);

  localparam int unsigned Off      = byte_off(DATA_WIDTH);
  localparam int unsigned NumBytes = DATA_WIDTH / 8;

  state_e                  state_q;
  logic [CntWidth-1:0]     cnt_q;
  logic                    we_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NumBytes-1:0]     mask_q;

  logic [DEPTH_LOG2-1:0]   req_idx;
  logic [NumBytes-1:0]     req_mask;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    complete;
  logic                    wr_en;
  logic                    unused_addr;

  // Offset bits and bits above the index are dropped: no alignment fault, index wraps.
  assign req_idx     = addr[Off +: DEPTH_LOG2];
  assign unused_addr = ^addr;

`ifdef LATENCY_RAM_BYTE_MASK_EN
  assign req_mask = byte_mask;
`else
  assign req_mask = '1;
`endif

  assign complete = (state_q == StBusy) && (cnt_q == '0);
  // Reset wins over a completing write so an aborted request never lands.
  assign wr_en    = complete && we_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      busy        <= 1'b0;
      hasFinished <= 1'b0;
      data_out    <= '0;
    end else begin
      hasFinished <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (en) begin
            we_q    <= we;
            idx_q   <= req_idx;
            wdata_q <= data_in;
            mask_q  <= req_mask;
            cnt_q   <= CntWidth'(LATENCY - 1);
            busy    <= 1'b1;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            if (!we_q) begin
              data_out <= rdata;
            end
            hasFinished <= 1'b1;
            busy        <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  latency_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .wr_en (wr_en),
    .idx   (idx_q),
    .wdata (wdata_q),
    .wmask (mask_q),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_latency_ram.sv
// Randomized self-checking bench for latency_ram against a word-array reference model.
module tb_latency_ram;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned DL  = 4;
  localparam int          LAT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [3:0]    byte_mask;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          hasFinished;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] model_mem [1 << DL];
  logic [DW-1:0] exp_out;

  always #5 clk = ~clk;

  latency_ram #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH_LOG2 (DL),
    .LATENCY    (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .we          (we),
    .addr        (addr),
    .data_in     (data_in),
`ifdef LATENCY_RAM_BYTE_MASK_EN
    .byte_mask   (byte_mask),
`endif
    .data_out    (data_out),
    .busy        (busy),
    .hasFinished (hasFinished)
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int word_of(input logic [AW-1:0] a);
    return int'((a / 4) % (1 << DL));
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                         input logic [3:0] m);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

  // One request; inject_at >= 0 pulses a stray write to 0x88 while busy.
  task automatic do_op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [3:0] m, input int inject_at);
    int  k;
    bit  done;
    logic [3:0] m_eff;
    @(negedge clk);
    en = 1'b1; we = w; addr = a; data_in = d; byte_mask = m;
    @(negedge clk);
    en = 1'b0; we = 1'($urandom); addr = $urandom; data_in = $urandom; byte_mask = 4'($urandom);
    check_eq("busy_start", 32'(busy), 32'd1);
    k = 0;
    done = 1'b0;
    while (!done && k < LAT + 4) begin
      if (k == inject_at) begin
        en = 1'b1; we = 1'b1; addr = 32'h88; data_in = $urandom;
      end else begin
        en = 1'b0;
      end
      @(negedge clk);
      k++;
      if (hasFinished) done = 1'b1;
      else check_eq("busy_hold", 32'(busy), 32'd1);
    end
    en = 1'b0;
    check_eq("latency", 32'(k), 32'(LAT));
`ifdef LATENCY_RAM_BYTE_MASK_EN
    m_eff = m;
`else
    m_eff = 4'hf;
`endif
    if (w) model_mem[word_of(a)] = merge(model_mem[word_of(a)], d, m_eff);
    else exp_out = model_mem[word_of(a)];
    check_eq("busy_end", 32'(busy), 32'd0);
    check_eq("data_out", data_out, exp_out);
    @(negedge clk);
    check_eq("pulse_width", 32'(hasFinished), 32'd0);
    check_eq("data_hold", data_out, exp_out);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; data_in = '0; byte_mask = '0;
    exp_out = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_fin", 32'(hasFinished), 32'd0);
    check_eq("rst_dout", data_out, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_fin", 32'(hasFinished), 32'd0);
      check_eq("idle_dout", data_out, 32'd0);
    end

    for (int i = 0; i < (1 << DL); i++) do_op(1'b1, AW'(i * 4), $urandom, 4'hf, -1);

    do_op(1'b1, 32'h40, 32'hDEADBEEF, 4'hf, -1);
    do_op(1'b0, 32'h40, 32'h0, 4'h0, -1);
    check_eq("rw_deadbeef", data_out, 32'hDEADBEEF);

    do_op(1'b0, 32'h40, 32'h0, 4'h0, 3);
    check_eq("busy_mask", data_out, 32'hDEADBEEF);

    do_op(1'b1, 32'h04, 32'h11, 4'hf, -1);
    do_op(1'b0, 32'h47, 32'h0, 4'h0, -1);
    check_eq("wrap_align", data_out, 32'h11);

    // Write aborted by reset three cycles after acceptance.
    @(negedge clk);
    en = 1'b1; we = 1'b1; addr = 32'h10; data_in = 32'h55; byte_mask = 4'hf;
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_out = '0;
    check_eq("abort_dout", data_out, 32'd0);
    for (int i = 0; i < LAT + 4; i++) begin
      check_eq("abort_fin", 32'(hasFinished), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    do_op(1'b0, 32'h10, 32'h0, 4'h0, -1);

`ifdef LATENCY_RAM_BYTE_MASK_EN
    do_op(1'b1, 32'h00, 32'hAABBCCDD, 4'hf, -1);
    do_op(1'b1, 32'h00, 32'h11223344, 4'b0101, -1);
    do_op(1'b0, 32'h00, 32'h0, 4'h0, -1);
    check_eq("byte_mask", data_out, 32'hAA22CC44);
    do_op(1'b1, 32'h00, 32'hFFFFFFFF, 4'h0, -1);
    do_op(1'b0, 32'h00, 32'h0, 4'h0, -1);
    check_eq("zero_mask", data_out, 32'hAA22CC44);
`endif

    for (int i = 0; i < 60; i++) begin
      int inj;
      inj = ($urandom % 3 == 0) ? int'($urandom_range(LAT - 2, 0)) : -1;
      do_op(1'($urandom), $urandom, $urandom, 4'($urandom), inj);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
